jk_bank_writer: RTL and testbench

Command sequencer that sits directly upstream of the JK flip-flop register bank (WORDS words of WIDTH JK cells each).
- Accepts write/clear/set/toggle commands over a valid/ready handshake.
- Translates each command into per-bit J/K drive, a one-hot word select and a single clock-enable pulse.
- Reads back the selected word and reports completion (done) or mismatch (err).
- Keeps a saturating error counter for the bench and for higher-level control.

---
 rtl/jk_bank_pkg.sv | 28 ++
 rtl/jk_drive_enc.sv | 51 +++++
 rtl/jk_bank_writer.sv | 183 ++++++++++++++++++
 tb/tb_jk_bank_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_pkg
// Description : Shared encodings for the JK register bank command sequencer:
//               command opcodes, sequencer state encoding, counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_pkg;

  // Width of the saturating error counter
  localparam int ERR_CNT_W = 8;

  // Command opcodes as they appear on cmd_op
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Sequencer states; IDLE must stay at zero so preset lands there
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

endpackage : jk_bank_pkg
`default_nettype wire

// File: rtl/jk_drive_enc.sv
`default_nettype none
// ============================================================================
// Module      : jk_drive_enc
// Description : Combinational translation of a command (op + data) into the
//               per-bit J/K drive vectors, plus the word value the bank must
//               read back once the command has been applied.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_drive_enc
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] old,       // word contents before the update edge
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] expected
);

  // J/K drive and post-update readback value for each opcode
  always_comb begin
    j        = '0;
    k        = '0;
    expected = '0;
    case (op)
      OP_WRITE: begin
        // J=1,K=0 sets a cell, J=0,K=1 clears it: one of the two per bit
        j        = data;
        k        = ~data;
        expected = data;
      end
      OP_CLEAR: begin
        k        = '1;
        expected = '0;
      end
      OP_SET: begin
        j        = '1;
        expected = '1;
      end
      default: begin  // OP_TOGGLE
        j        = '1;
        k        = '1;
        expected = ~old;
      end
    endcase
  end

endmodule : jk_drive_enc
`default_nettype wire

// File: rtl/jk_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_writer
// Description : Command sequencer in front of a JK flip-flop register bank.
//               Accepts one command per handshake, drives J/K + one-hot
//               select with a single clock-enable pulse, reads the word back
//               and reports done/err, keeping a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_writer
  import jk_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 preset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic [WIDTH-1:0]     jk_j,
  output logic [WIDTH-1:0]     jk_k,
  output logic [WORDS-1:0]     jk_sel,
  output logic                 jk_clk_en,
  input  logic [WIDTH-1:0]     q_rd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     old_q, old_d;
  logic                 mismatch_q, mismatch_d;
  logic                 bad_addr_q, bad_addr_d;
  logic [WIDTH-1:0]     jk_j_q, jk_j_d;
  logic [WIDTH-1:0]     jk_k_q, jk_k_d;
  logic [WORDS-1:0]     jk_sel_q, jk_sel_d;
  logic                 jk_clk_en_q, jk_clk_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 accept;
  logic                 addr_bad;
  logic [WORDS-1:0]     sel_onehot;
  logic [1:0]           enc_op;
  logic [WIDTH-1:0]     enc_data;
  logic [WIDTH-1:0]     enc_j;
  logic [WIDTH-1:0]     enc_k;
  logic [WIDTH-1:0]     enc_expected;

  assign cmd_ready = (state_q == ST_IDLE) & ~preset;
  assign accept    = cmd_valid & cmd_ready;
  assign addr_bad  = (int'(cmd_addr) >= WORDS);

  // One-hot decode of the incoming address (all zero for a bad address)
  for (genvar i = 0; i < WORDS; i++) begin : g_sel
    assign sel_onehot[i] = (int'(cmd_addr) == i);
  end

  // The encoder sees the live command while idle (to register the DRIVE
  // pattern at acceptance) and the latched command afterwards (to produce
  // the expected readback during SETTLE).
  assign enc_op   = (state_q == ST_IDLE) ? cmd_op   : op_q;
  assign enc_data = (state_q == ST_IDLE) ? cmd_data : data_q;

  jk_drive_enc #(
    .WIDTH    (WIDTH)
  ) u_enc (
    .op       (enc_op),
    .data     (enc_data),
    .old      (old_q),
    .j        (enc_j),
    .k        (enc_k),
    .expected (enc_expected)
  );

  // Next-state and next-output logic; outputs default to quiescent
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    old_d       = old_q;
    mismatch_d  = mismatch_q;
    bad_addr_d  = bad_addr_q;
    jk_j_d      = '0;
    jk_k_d      = '0;
    jk_sel_d    = '0;
    jk_clk_en_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = cmd_op;
          data_d     = cmd_data;
          bad_addr_d = addr_bad;
          mismatch_d = 1'b0;
          if (addr_bad) begin
            // Never touch the bank for an out-of-range word
            state_d = ST_CHECK;
          end else begin
            state_d     = ST_DRIVE;
            jk_sel_d    = sel_onehot;
            jk_j_d      = enc_j;
            jk_k_d      = enc_k;
            jk_clk_en_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        // q_rd still shows the pre-edge word; toggle needs it as reference
        old_d    = q_rd;
        jk_sel_d = jk_sel_q;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        mismatch_d = (q_rd != enc_expected);
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        done_d = 1'b1;
        err_d  = mismatch_q | bad_addr_q;
        if (err_d && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; preset aborts any command in flight
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      old_q       <= '0;
      mismatch_q  <= 1'b0;
      bad_addr_q  <= 1'b0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      jk_sel_q    <= '0;
      jk_clk_en_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      old_q       <= old_d;
      mismatch_q  <= mismatch_d;
      bad_addr_q  <= bad_addr_d;
      jk_j_q      <= jk_j_d;
      jk_k_q      <= jk_k_d;
      jk_sel_q    <= jk_sel_d;
      jk_clk_en_q <= jk_clk_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign jk_sel    = jk_sel_q;
  assign jk_clk_en = jk_clk_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : jk_bank_writer
`default_nettype wire

// File: tb/tb_jk_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_writer
// Description : Directed self-checking bench for jk_bank_writer with a
//               behavioural JK bank (optional stuck-at-0 cell on word1 bit3)
//               and a second WORDS=3 instance for the bad-address case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_writer;

  logic       clk = 1'b0;
  logic       preset = 1'b1;

  // Main instance, WORDS=4
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_addr = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] jk_j, jk_k, q_rd;
  logic [3:0] jk_sel;
  logic       jk_clk_en, busy, done, err;
  logic [7:0] err_cnt;

  // Second instance, WORDS=3, no bank attached
  logic       v3 = 1'b0;
  logic       rdy3;
  logic [1:0] addr3 = 2'd0;
  logic [7:0] j3, k3;
  logic [2:0] sel3;
  logic       en3, busy3, done3, err3;
  logic [7:0] cnt3;

  logic [7:0] bank [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       stuck_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_bank_writer #(.WIDTH(8), .WORDS(4), .ADDR_W(2)) dut (
    .clk(clk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .jk_j(jk_j), .jk_k(jk_k), .jk_sel(jk_sel), .jk_clk_en(jk_clk_en),
    .q_rd(q_rd), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  jk_bank_writer #(.WIDTH(8), .WORDS(3), .ADDR_W(2)) dut3 (
    .clk(clk), .preset(preset), .cmd_valid(v3), .cmd_ready(rdy3),
    .cmd_op(2'b00), .cmd_addr(addr3), .cmd_data(8'hC3),
    .jk_j(j3), .jk_k(k3), .jk_sel(sel3), .jk_clk_en(en3),
    .q_rd(8'h00), .busy(busy3), .done(done3), .err(err3), .err_cnt(cnt3)
  );

  // Behavioural JK bank: selected word updates on posedge when enabled
  always @(posedge clk) begin
    if (jk_clk_en) begin
      for (int w = 0; w < 4; w++) begin
        if (jk_sel[w]) begin
          for (int b = 0; b < 8; b++) begin
            case ({jk_j[b], jk_k[b]})
              2'b10:   bank[w][b] <= 1'b1;
              2'b01:   bank[w][b] <= 1'b0;
              2'b11:   bank[w][b] <= ~bank[w][b];
              default: bank[w][b] <= bank[w][b];
            endcase
          end
        end
      end
    end
  end

  // Combinational readback mux with optional stuck-at-0 fault
  always_comb begin
    q_rd = 8'h00;
    for (int w = 0; w < 4; w++) begin
      if (jk_sel[w]) q_rd = bank[w];
    end
    if (stuck_en && jk_sel[1]) q_rd[3] = 1'b0;
  end

  // Issue one command on the main instance and observe it until done
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data,
                         output int lat, output logic [7:0] j, output logic [7:0] k,
                         output logic [3:0] sel, output int en_cnt, output logic e,
                         output logic [7:0] settle_jk);
    int g = 0;
    lat = 0; en_cnt = 0; e = 1'b0; j = '0; k = '0; sel = '0; settle_jk = 8'hEE;
    @(negedge clk);
    while (!cmd_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (jk_clk_en) en_cnt++;
      if (c == 1) begin j = jk_j; k = jk_k; sel = jk_sel; end
      if (c == 2) settle_jk = jk_j | jk_k;
      if (done) begin lat = c; e = err; break; end
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 2'd0;  // must be discarded
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, err, jk_clk_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {cmd_ready, busy, done, err, jk_clk_en});
    end
    n_checks++;
    if ({jk_j, jk_k, jk_sel, err_cnt} !== 28'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {jk_j, jk_k, jk_sel, err_cnt});
    end
    cmd_valid = 1'b0;
    preset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_release: ready=%b cnt=%0d want 1/0", cmd_ready, err_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bank[0] !== 8'h00) begin
      n_fail++; $display("FAIL reset_discard: busy=%b bank0=%h want 0/00", busy, bank[0]);
    end
  endtask

  task automatic test_write();
    int lat, en; logic [7:0] j, k, sj; logic [3:0] sel; logic e;
    run_cmd(2'b00, 2'd2, 8'hA5, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (sel !== 4'b0100 || j !== 8'hA5 || k !== 8'h5A) begin
      n_fail++; $display("FAIL write_drive: sel=%b j=%h k=%h want 0100/a5/5a", sel, j, k);
    end
    n_checks++;
    if (lat !== 4 || en !== 1 || sj !== 8'h00) begin
      n_fail++; $display("FAIL write_timing: lat=%0d en=%0d settle_jk=%h want 4/1/00", lat, en, sj);
    end
    n_checks++;
    if (e !== 1'b0 || bank[2] !== 8'hA5 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL write_result: err=%b word2=%h cnt=%0d want 0/a5/0", e, bank[2], err_cnt);
    end
  endtask

  task automatic test_ops();
    int lat, en; logic [7:0] j, k, sj; logic [3:0] sel; logic e;
    run_cmd(2'b11, 2'd2, 8'h00, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (j !== 8'hFF || k !== 8'hFF || bank[2] !== 8'h5A || e !== 1'b0 || lat !== 4) begin
      n_fail++; $display("FAIL toggle: j=%h k=%h word2=%h err=%b lat=%0d want ff/ff/5a/0/4", j, k, bank[2], e, lat);
    end
    run_cmd(2'b10, 2'd0, 8'h00, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (j !== 8'hFF || k !== 8'h00 || sel !== 4'b0001 || bank[0] !== 8'hFF || e !== 1'b0) begin
      n_fail++; $display("FAIL set: j=%h k=%h sel=%b word0=%h err=%b want ff/00/0001/ff/0", j, k, sel, bank[0], e);
    end
    run_cmd(2'b01, 2'd0, 8'hFF, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (j !== 8'h00 || k !== 8'hFF || bank[0] !== 8'h00 || e !== 1'b0 || en !== 1) begin
      n_fail++; $display("FAIL clear: j=%h k=%h word0=%h err=%b en=%0d want 00/ff/00/0/1", j, k, bank[0], e, en);
    end
  endtask

  task automatic test_stuck_saturate();
    int lat, en; logic [7:0] j, k, sj; logic [3:0] sel; logic e;
    stuck_en = 1'b1;
    run_cmd(2'b00, 2'd1, 8'h01, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (e !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL stuck_clean: err=%b cnt=%0d want 0/0", e, err_cnt);
    end
    run_cmd(2'b00, 2'd1, 8'h08, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (e !== 1'b1 || err_cnt !== 8'd1 || lat !== 4) begin
      n_fail++; $display("FAIL stuck_err: err=%b cnt=%0d lat=%0d want 1/1/4", e, err_cnt, lat);
    end
    for (int i = 0; i < 253; i++) run_cmd(2'b00, 2'd1, 8'h08, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (err_cnt !== 8'd254) begin
      n_fail++; $display("FAIL cnt_254: got %0d want 254", err_cnt);
    end
    for (int i = 0; i < 46; i++) run_cmd(2'b00, 2'd1, 8'h08, lat, j, k, sel, en, e, sj);
    n_checks++;
    if (err_cnt !== 8'd255 || e !== 1'b1) begin
      n_fail++; $display("FAIL cnt_saturate: cnt=%0d err=%b want 255/1", err_cnt, e);
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_bad_addr();
    int lat = 0; logic drove = 1'b0; logic e = 1'b0;
    @(negedge clk);
    v3 = 1'b1; addr3 = 2'd3;
    n_checks++;
    if (rdy3 !== 1'b1) begin
      n_fail++; $display("FAIL bad_ready: got %b want 1", rdy3);
    end
    @(posedge clk);
    #1 v3 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (en3 || sel3 != 3'b000 || j3 != 8'h00 || k3 != 8'h00) drove = 1'b1;
      if (done3 && lat == 0) begin lat = c; e = err3; end
    end
    n_checks++;
    if (drove !== 1'b0 || lat !== 2 || e !== 1'b1 || cnt3 !== 8'd1) begin
      n_fail++; $display("FAIL bad_addr: drove=%b lat=%0d err=%b cnt=%0d want 0/2/1/1", drove, lat, e, cnt3);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 8'h55;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);   // DRIVE
    @(negedge clk);   // SETTLE
    preset = 1'b1;
    #1;
    n_checks++;
    if ({busy, jk_clk_en, cmd_ready, done, err} !== 5'b0 || jk_sel !== 4'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset: ctl=%b sel=%b cnt=%0d want 0/0/0",
                         {busy, jk_clk_en, cmd_ready, done, err}, jk_sel, err_cnt);
    end
    @(negedge clk);
    preset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || err_cnt !== 8'd0 || cnt3 !== 8'd0) begin
      n_fail++; $display("FAIL mid_abort: done_or_err=%b cnt=%0d cnt3=%0d want 0/0/0", seen, err_cnt, cnt3);
    end
  endtask

  task automatic test_back_to_back();
    int acc[2] = '{0, 0};
    int n = 0;
    int cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 8'h11;
    while (n < 2 && cyc < 30) begin
      if (cmd_ready && cmd_valid) begin acc[n] = cyc; n++; end
      @(negedge clk);
      cyc++;
      if (n == 1) begin cmd_addr = 2'd3; cmd_data = 8'h22; end
    end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n !== 2 || (acc[1] - acc[0]) !== 4) begin
      n_fail++; $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2/4", n, acc[1] - acc[0]);
    end
    n_checks++;
    if (bank[0] !== 8'h11 || bank[3] !== 8'h22 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL b2b_data: w0=%h w3=%h cnt=%0d want 11/22/0", bank[0], bank[3], err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ops();
    test_stuck_saturate();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_jk_bank_writer
`default_nettype wire
